// File: rtl/ahb3lite_interconnect_master_port_if.sv
// Bus bundle between one AHB3-Lite master and its interconnect master port.
// Handshake: an address phase transfers on the rising HCLK edge where
// mst_HSEL & mst_HREADY & mst_HREADYOUT are all high; a data phase completes
// on the edge where the owning side's HREADYOUT is high. Slave-side signals
// follow the same rule with slvHSEL / slvHREADY / slvHREADYOUT.
interface ahb3lite_interconnect_master_port_if #(
    parameter int HADDR_SIZE = 32,
    parameter int HDATA_SIZE = 32,
    parameter int SLAVES     = 8
);
    // master side
    logic                  mst_HSEL;
    logic [HADDR_SIZE-1:0] mst_HADDR;
    logic [HDATA_SIZE-1:0] mst_HWDATA;
    logic [HDATA_SIZE-1:0] mst_HRDATA;
    logic                  mst_HWRITE;
    logic [2:0]            mst_HSIZE;
    logic [2:0]            mst_HBURST;
    logic [3:0]            mst_HPROT;
    logic [1:0]            mst_HTRANS;
    logic                  mst_HMASTLOCK;
    logic                  mst_HREADY;
    logic                  mst_HREADYOUT;
    logic                  mst_HRESP;

    // slave side
    logic [SLAVES-1:0][HADDR_SIZE-1:0] slvHADDRbase;
    logic [SLAVES-1:0][HADDR_SIZE-1:0] slvHADDRmask;
    logic [SLAVES-1:0]                 slvHSEL;
    logic [HADDR_SIZE-1:0]             slvHADDR;
    logic [HDATA_SIZE-1:0]             slvHWDATA;
    logic                              slvHWRITE;
    logic [2:0]                        slvHSIZE;
    logic [2:0]                        slvHBURST;
    logic [3:0]                        slvHPROT;
    logic [1:0]                        slvHTRANS;
    logic                              slvHMASTLOCK;
    logic                              slvHREADY;
    logic [SLAVES-1:0][HDATA_SIZE-1:0] slvHRDATA;
    logic [SLAVES-1:0]                 slvHREADYOUT;
    logic [SLAVES-1:0]                 slvHRESP;
    logic [SLAVES-1:0]                 slv_granted;
    logic [SLAVES-1:0]                 can_switch;

    // the interconnect port itself
    modport slave (
        input  mst_HSEL, mst_HADDR, mst_HWDATA, mst_HWRITE, mst_HSIZE, mst_HBURST,
               mst_HPROT, mst_HTRANS, mst_HMASTLOCK, mst_HREADY,
        output mst_HRDATA, mst_HREADYOUT, mst_HRESP,
        input  slvHADDRbase, slvHADDRmask, slvHRDATA, slvHREADYOUT, slvHRESP, slv_granted,
        output slvHSEL, slvHADDR, slvHWDATA, slvHWRITE, slvHSIZE, slvHBURST, slvHPROT,
               slvHTRANS, slvHMASTLOCK, slvHREADY, can_switch
    );

    // the environment around the port (AHB master plus slave ports)
    modport master (
        output mst_HSEL, mst_HADDR, mst_HWDATA, mst_HWRITE, mst_HSIZE, mst_HBURST,
               mst_HPROT, mst_HTRANS, mst_HMASTLOCK, mst_HREADY,
        input  mst_HRDATA, mst_HREADYOUT, mst_HRESP,
        output slvHADDRbase, slvHADDRmask, slvHRDATA, slvHREADYOUT, slvHRESP, slv_granted,
        input  slvHSEL, slvHADDR, slvHWDATA, slvHWRITE, slvHSIZE, slvHBURST, slvHPROT,
               slvHTRANS, slvHMASTLOCK, slvHREADY, can_switch
    );
endinterface

// File: rtl/ahb3lite_interconnect_master_port.sv
// Master-side port of the AHB3-Lite multi-layer switch. Decodes the master
// address onto one slave port, stalls the master until that port grants it,
// answers unmapped addresses with a two-cycle ERROR response and routes the
// data-phase response back from the slave port owning the data phase.
module ahb3lite_interconnect_master_port #(
    parameter int HADDR_SIZE = 32,
    parameter int HDATA_SIZE = 32,
    parameter int SLAVES     = 8
) (
    input  logic HRESETn,
    input  logic HCLK,
    ahb3lite_interconnect_master_port_if.slave bus,
    output logic [2:0] dbg_state
);
    localparam int SLAVE_BITS = (SLAVES > 1) ? $clog2(SLAVES) : 1;

    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DATA = 3'd1,
        ST_WAIT = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_t;

    state_t                state;
    state_t                acc_state;
    logic [SLAVE_BITS-1:0] dp_idx;
    logic [SLAVE_BITS-1:0] dec_idx;
    logic                  dec_hit;
    logic                  accept;
    logic                  addr_slot;

    // address phase held while waiting for a grant
    logic [SLAVE_BITS-1:0] hold_idx;
    logic [HADDR_SIZE-1:0] hold_addr;
    logic                  hold_write;
    logic [2:0]            hold_size;
    logic [2:0]            hold_burst;
    logic [3:0]            hold_prot;
    logic [1:0]            hold_trans;
    logic                  hold_lock;

    logic [SLAVES-1:0]     sel_c;
    logic [SLAVES-1:0]     can_switch_c;

    assign dbg_state = state;

    // address decode; scanning downwards lets the lowest matching index win
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        for (int s = SLAVES - 1; s >= 0; s--) begin
            if ((bus.slvHADDRmask[s] != '0) &&
                (((bus.mst_HADDR ^ bus.slvHADDRbase[s]) & bus.slvHADDRmask[s]) == '0)) begin
                dec_hit = 1'b1;
                dec_idx = SLAVE_BITS'(s);
            end
        end
    end

    // master-facing response, selected by the current state
    always_comb begin
        bus.mst_HREADYOUT = 1'b1;
        bus.mst_HRESP     = 1'b0;
        case (state)
            ST_IDLE: begin
                bus.mst_HREADYOUT = 1'b1;
                bus.mst_HRESP     = 1'b0;
            end
            ST_DATA: begin
                bus.mst_HREADYOUT = bus.slvHREADYOUT[dp_idx];
                bus.mst_HRESP     = bus.slvHRESP[dp_idx];
            end
            ST_WAIT: begin
                bus.mst_HREADYOUT = 1'b0;
                bus.mst_HRESP     = 1'b0;
            end
            ST_ERR1: begin
                bus.mst_HREADYOUT = 1'b0;
                bus.mst_HRESP     = 1'b1;
            end
            ST_ERR2: begin
                bus.mst_HREADYOUT = 1'b1;
                bus.mst_HRESP     = 1'b1;
            end
            default: begin
                bus.mst_HREADYOUT = 1'b1;
                bus.mst_HRESP     = 1'b0;
            end
        endcase
    end

    assign bus.mst_HRDATA = bus.slvHRDATA[dp_idx];

    // accept decision for a sampled address phase; only NONSEQ/SEQ are active
    always_comb begin
        accept    = bus.mst_HSEL & bus.mst_HREADY & bus.mst_HREADYOUT & bus.mst_HTRANS[1];
        addr_slot = (state == ST_IDLE) || (state == ST_ERR2) ||
                    ((state == ST_DATA) && bus.slvHREADYOUT[dp_idx]);
        if (!accept)                        acc_state = ST_IDLE;
        else if (!dec_hit)                  acc_state = ST_ERR1;
        else if (bus.slv_granted[dec_idx])  acc_state = ST_DATA;
        else                                acc_state = ST_WAIT;
    end

    // transfer-tracking FSM with data-phase owner and grant-wait hold register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state      <= ST_IDLE;
            dp_idx     <= '0;
            hold_idx   <= '0;
            hold_addr  <= '0;
            hold_write <= 1'b0;
            hold_size  <= '0;
            hold_burst <= '0;
            hold_prot  <= '0;
            hold_trans <= '0;
            hold_lock  <= 1'b0;
        end else if (addr_slot) begin
            state <= acc_state;
            if (acc_state == ST_DATA) begin
                dp_idx <= dec_idx;
            end
            if (acc_state == ST_WAIT) begin
                hold_idx   <= dec_idx;
                hold_addr  <= bus.mst_HADDR;
                hold_write <= bus.mst_HWRITE;
                hold_size  <= bus.mst_HSIZE;
                hold_burst <= bus.mst_HBURST;
                hold_prot  <= bus.mst_HPROT;
                hold_trans <= bus.mst_HTRANS;
                hold_lock  <= bus.mst_HMASTLOCK;
            end
        end else begin
            case (state)
                ST_WAIT: begin
                    if (bus.slv_granted[hold_idx] && bus.slvHREADYOUT[hold_idx]) begin
                        state  <= ST_DATA;
                        dp_idx <= hold_idx;
                    end
                end
                ST_ERR1: state <= ST_ERR2;
                default: state <= state;
            endcase
        end
    end

    // slave-facing address phase: held transfer in WAIT, live pass-through otherwise
    always_comb begin
        sel_c = '0;
        if (state == ST_WAIT) begin
            sel_c[hold_idx]  = 1'b1;
            bus.slvHADDR     = hold_addr;
            bus.slvHWRITE    = hold_write;
            bus.slvHSIZE     = hold_size;
            bus.slvHBURST    = hold_burst;
            bus.slvHPROT     = hold_prot;
            // the slave port sees a fresh transfer, so a held SEQ restarts as NONSEQ
            bus.slvHTRANS    = (hold_trans == HTRANS_SEQ) ? HTRANS_NONSEQ : hold_trans;
            bus.slvHMASTLOCK = hold_lock;
            bus.slvHREADY    = bus.slvHREADYOUT[hold_idx];
        end else begin
            if (dec_hit && HRESETn) begin
                sel_c[dec_idx] = bus.mst_HSEL;
            end
            bus.slvHADDR     = bus.mst_HADDR;
            bus.slvHWRITE    = bus.mst_HWRITE;
            bus.slvHSIZE     = bus.mst_HSIZE;
            bus.slvHBURST    = bus.mst_HBURST;
            bus.slvHPROT     = bus.mst_HPROT;
            bus.slvHTRANS    = bus.mst_HTRANS;
            bus.slvHMASTLOCK = bus.mst_HMASTLOCK;
            bus.slvHREADY    = bus.mst_HREADYOUT;
        end
    end

    assign bus.slvHSEL   = sel_c;
    assign bus.slvHWDATA = bus.mst_HWDATA;

    // a slave port must not re-arbitrate in the middle of a locked or burst sequence
    always_comb begin
        for (int s = 0; s < SLAVES; s++) begin
            can_switch_c[s] = ~(sel_c[s] & (bus.slvHMASTLOCK | bus.slvHTRANS[0]));
        end
    end

    assign bus.can_switch = can_switch_c;
endmodule

// File: tb/tb_ahb3lite_interconnect_master_port.sv
// Self-checking bench for the AHB3-Lite interconnect master port.
module tb_ahb3lite_interconnect_master_port;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NS = 8;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_DATA = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_ERR1 = 3'd3;
    localparam logic [2:0] S_ERR2 = 3'd4;

    logic       HCLK;
    logic       HRESETn;
    logic [2:0] dbg_state;

    ahb3lite_interconnect_master_port_if #(.HADDR_SIZE(AW), .HDATA_SIZE(DW), .SLAVES(NS)) bus ();

    ahb3lite_interconnect_master_port #(.HADDR_SIZE(AW), .HDATA_SIZE(DW), .SLAVES(NS)) dut (
        .HRESETn   (HRESETn),
        .HCLK      (HCLK),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int n_vec  = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  trans;
        logic        sel;
        logic        lock;
        logic [7:0]  granted;
        logic [7:0]  exp_hsel;
        logic [7:0]  exp_cs;
        logic [2:0]  exp_state;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // scoreboard: compare the oldest expectation against what the DUT shows now
    task automatic sb_check(input string name, input logic [31:0] act);
        if (exp_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, got 0x%0h", name, act);
        end else begin
            check(name, act, exp_q.pop_front());
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive_addr(input logic sel, input logic [31:0] addr, input logic [1:0] trans,
                              input logic write, input logic lock);
        bus.mst_HSEL      = sel;
        bus.mst_HADDR     = addr;
        bus.mst_HTRANS    = trans;
        bus.mst_HWRITE    = write;
        bus.mst_HMASTLOCK = lock;
    endtask

    task automatic master_idle();
        drive_addr(1'b0, 32'h0, 2'b00, 1'b0, 1'b0);
    endtask

    // bring the port back to IDLE with a bounded number of cycles
    task automatic go_idle();
        master_idle();
        bus.slv_granted  = '1;
        bus.slvHREADYOUT = '1;
        for (int i = 0; i < 8; i++) begin
            if (dbg_state == S_IDLE) break;
            step();
        end
        check("go_idle", {29'd0, dbg_state}, {29'd0, S_IDLE});
    endtask

    initial begin
        // stimulus table: each entry is one address phase presented in IDLE
        //           addr        trans  sel   lock  granted  hsel   cs     next state
        vecs[0]  = '{32'h0000_1004, 2'b10, 1'b1, 1'b0, 8'hFF, 8'h02, 8'hFF, S_DATA};
        vecs[1]  = '{32'h0000_2000, 2'b10, 1'b1, 1'b0, 8'h00, 8'h04, 8'hFF, S_WAIT};
        vecs[2]  = '{32'h0000_F000, 2'b10, 1'b1, 1'b0, 8'hFF, 8'h00, 8'hFF, S_ERR1};
        vecs[3]  = '{32'h0000_0010, 2'b10, 1'b1, 1'b1, 8'hFF, 8'h01, 8'hFE, S_DATA};
        vecs[4]  = '{32'h0000_3000, 2'b11, 1'b1, 1'b0, 8'hFF, 8'h08, 8'hF7, S_DATA};
        vecs[5]  = '{32'h0000_3000, 2'b01, 1'b1, 1'b0, 8'hFF, 8'h08, 8'hF7, S_IDLE};
        vecs[6]  = '{32'h0000_1000, 2'b00, 1'b1, 1'b0, 8'hFF, 8'h02, 8'hFF, S_IDLE};
        vecs[7]  = '{32'h0000_1000, 2'b10, 1'b0, 1'b0, 8'hFF, 8'h00, 8'hFF, S_IDLE};
        vecs[8]  = '{32'h0000_4000, 2'b10, 1'b1, 1'b0, 8'hFF, 8'h00, 8'hFF, S_ERR1};
        vecs[9]  = '{32'h0000_5004, 2'b10, 1'b1, 1'b0, 8'hFF, 8'h20, 8'hFF, S_DATA};
        vecs[10] = '{32'h0000_5004, 2'b10, 1'b1, 1'b0, 8'hDF, 8'h20, 8'hFF, S_WAIT};
        vecs[11] = '{32'h0000_7FFC, 2'b10, 1'b1, 1'b1, 8'hFF, 8'h00, 8'hFF, S_ERR1};

        // decode map: 0..3 on 4 KB windows, 4 and 7 disabled (mask 0),
        // 5 and 6 overlap at 0x5000..0x57FF so the lower index must win
        for (int s = 0; s < NS; s++) begin
            bus.slvHADDRbase[s] = 32'(s) << 12;
            bus.slvHADDRmask[s] = 32'h0000_F000;
            bus.slvHRDATA[s]    = 32'h1111_0000 + 32'(s);
        end
        bus.slvHADDRmask[4] = 32'h0;
        bus.slvHADDRbase[6] = 32'h0000_5000;
        bus.slvHADDRmask[6] = 32'h0000_F800;
        bus.slvHADDRmask[7] = 32'h0;
        bus.slvHADDRbase[7] = 32'h0;
        bus.slvHRDATA[2]    = 32'hDEAD_BEEF;
        bus.slvHREADYOUT    = '1;
        bus.slvHRESP        = '0;
        bus.slv_granted     = '1;
        bus.mst_HREADY      = 1'b1;
        bus.mst_HWDATA      = '0;
        bus.mst_HSIZE       = 3'b010;
        bus.mst_HBURST      = 3'b000;
        bus.mst_HPROT       = 4'b0011;
        master_idle();

        // reset state
        HRESETn = 1'b0;
        #1;
        check("rst_hreadyout", {31'd0, bus.mst_HREADYOUT}, 32'd1);
        check("rst_hresp", {31'd0, bus.mst_HRESP}, 32'd0);
        check("rst_slvhsel", {24'd0, bus.slvHSEL}, 32'd0);
        check("rst_can_switch", {24'd0, bus.can_switch}, 32'hFF);
        check("rst_state", {29'd0, dbg_state}, {29'd0, S_IDLE});
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;
        step();

        // table-driven single address phases
        for (int i = 0; i < 12; i++) begin
            go_idle();
            bus.slv_granted = vecs[i].granted;
            drive_addr(vecs[i].sel, vecs[i].addr, vecs[i].trans, 1'b0, vecs[i].lock);
            #1;
            check($sformatf("v%0d_hsel", i), {24'd0, bus.slvHSEL}, {24'd0, vecs[i].exp_hsel});
            check($sformatf("v%0d_cs", i), {24'd0, bus.can_switch}, {24'd0, vecs[i].exp_cs});
            check($sformatf("v%0d_hreadyout", i), {31'd0, bus.mst_HREADYOUT}, 32'd1);
            exp_q.push_back({29'd0, vecs[i].exp_state});
            step();
            master_idle();
            sb_check($sformatf("v%0d_state", i), {29'd0, dbg_state});
        end

        // granted write: select same cycle, data phase follows slave ready
        go_idle();
        drive_addr(1'b1, 32'h0000_1004, 2'b10, 1'b1, 1'b0);
        #1;
        check("wr_hsel", {24'd0, bus.slvHSEL}, 32'h02);
        check("wr_hwrite", {31'd0, bus.slvHWRITE}, 32'd1);
        step();
        check("wr_state", {29'd0, dbg_state}, {29'd0, S_DATA});
        master_idle();
        bus.mst_HWDATA = 32'h0000_A5A5;
        bus.slvHREADYOUT[1] = 1'b0;
        #1;
        check("wr_hreadyout_low", {31'd0, bus.mst_HREADYOUT}, 32'd0);
        check("wr_slvhready_low", {31'd0, bus.slvHREADY}, 32'd0);
        check("wr_hwdata", bus.slvHWDATA, 32'h0000_A5A5);
        step();
        check("wr_state_stall", {29'd0, dbg_state}, {29'd0, S_DATA});
        bus.slvHREADYOUT[1] = 1'b1;
        #1;
        check("wr_hreadyout_high", {31'd0, bus.mst_HREADYOUT}, 32'd1);
        step();
        check("wr_state_done", {29'd0, dbg_state}, {29'd0, S_IDLE});

        // ungranted read: hold in WAIT, then DATA once granted
        go_idle();
        bus.slv_granted = 8'h00;
        drive_addr(1'b1, 32'h0000_2000, 2'b10, 1'b0, 1'b0);
        step();
        check("rd_state_wait", {29'd0, dbg_state}, {29'd0, S_WAIT});
        drive_addr(1'b1, 32'h0000_3000, 2'b11, 1'b1, 1'b0);
        #1;
        check("rd_hreadyout", {31'd0, bus.mst_HREADYOUT}, 32'd0);
        check("rd_htrans", {30'd0, bus.slvHTRANS}, 32'd2);
        check("rd_haddr_held", bus.slvHADDR, 32'h0000_2000);
        check("rd_hwrite_held", {31'd0, bus.slvHWRITE}, 32'd0);
        check("rd_hsel", {24'd0, bus.slvHSEL}, 32'h04);
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("rd_wait_c%0d", c), {29'd0, dbg_state}, {29'd0, S_WAIT});
        end
        bus.slv_granted = 8'h04;
        exp_q.push_back(32'hDEAD_BEEF);
        step();
        master_idle();
        check("rd_state_data", {29'd0, dbg_state}, {29'd0, S_DATA});
        #1;
        sb_check("rd_hrdata", bus.mst_HRDATA);
        check("rd_hreadyout_data", {31'd0, bus.mst_HREADYOUT}, 32'd1);

        // unmapped address: two-cycle ERROR response
        go_idle();
        drive_addr(1'b1, 32'h0000_F000, 2'b10, 1'b0, 1'b0);
        step();
        master_idle();
        #1;
        check("err1_state", {29'd0, dbg_state}, {29'd0, S_ERR1});
        check("err1_resp", {30'd0, bus.mst_HREADYOUT, bus.mst_HRESP}, 32'b01);
        step();
        check("err2_state", {29'd0, dbg_state}, {29'd0, S_ERR2});
        check("err2_resp", {30'd0, bus.mst_HREADYOUT, bus.mst_HRESP}, 32'b11);
        step();
        check("err_end_state", {29'd0, dbg_state}, {29'd0, S_IDLE});
        check("err_end_resp", {30'd0, bus.mst_HREADYOUT, bus.mst_HRESP}, 32'b10);

        // locked INCR4 to slave 0: no re-arbitration until the closing IDLE
        go_idle();
        bus.mst_HBURST = 3'b011;
        for (int b = 0; b < 4; b++) begin
            drive_addr(1'b1, 32'(b * 4), (b == 0) ? 2'b10 : 2'b11, 1'b0, 1'b1);
            #1;
            check($sformatf("lock_beat%0d_cs0", b), {31'd0, bus.can_switch[0]}, 32'd0);
            step();
        end
        drive_addr(1'b1, 32'h0000_0010, 2'b00, 1'b0, 1'b0);
        #1;
        check("lock_end_cs0", {31'd0, bus.can_switch[0]}, 32'd1);
        step();
        bus.mst_HBURST = 3'b000;

        // SEQ to ungranted slave 3 restarts as NONSEQ; reset aborts the wait
        go_idle();
        bus.slv_granted = 8'h00;
        drive_addr(1'b1, 32'h0000_3000, 2'b11, 1'b0, 1'b0);
        step();
        check("seq_wait_state", {29'd0, dbg_state}, {29'd0, S_WAIT});
        check("seq_wait_htrans", {30'd0, bus.slvHTRANS}, 32'd2);
        check("seq_wait_hsel", {24'd0, bus.slvHSEL}, 32'h08);
        #2;
        HRESETn = 1'b0;
        #1;
        check("arst_hsel", {24'd0, bus.slvHSEL}, 32'd0);
        check("arst_hreadyout", {31'd0, bus.mst_HREADYOUT}, 32'd1);
        check("arst_state", {29'd0, dbg_state}, {29'd0, S_IDLE});
        master_idle();
        @(negedge HCLK);
        HRESETn = 1'b1;
        step();
        check("arst_post_state", {29'd0, dbg_state}, {29'd0, S_IDLE});
        check("arst_post_hsel", {24'd0, bus.slvHSEL}, 32'd0);

        if (exp_q.size() != 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL sb_leftover: %0d entries, want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    // global watchdog so the run always ends
    initial begin
        #50000;
        $display("FAIL watchdog: timeout reached, want completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail + 1);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ahb3lite_interconnect_master_port.md
Name: ahb3lite_interconnect_master_port

Overview:
- Master-side port of the AHB3-Lite multi-layer switch; one instance per AHB master.
- Decodes the master's address onto one of SLAVES slave ports and forwards the address phase to it.
- Holds the transfer (HREADYOUT low) until the target slave port grants this master, and generates an AHB ERROR response for unmapped addresses.
- Muxes the data-phase response (HRDATA/HREADYOUT/HRESP) back from the slave port that owns the current data phase.

Parameters:
- HADDR_SIZE, 32, address width.
- HDATA_SIZE, 32, data width.
- SLAVES, 8, number of slave ports.
- SLAVE_BITS, $clog2(SLAVES), slave index width (localparam).

Ports:
HRESETn  in  1  asynchronous reset, active-low
HCLK  in  1  clock, rising edge
mst_HSEL  in  1  master select
mst_HADDR  in  HADDR_SIZE  master address
mst_HWDATA  in  HDATA_SIZE  master write data
mst_HRDATA  out  HDATA_SIZE  read data to master
mst_HWRITE  in  1  write
mst_HSIZE, mst_HBURST  in  3 each  size / burst
mst_HPROT  in  4  protection
mst_HTRANS  in  2  transfer type
mst_HMASTLOCK  in  1  locked sequence
mst_HREADY  in  1  bus HREADY
mst_HREADYOUT  out  1  ready to master bus
mst_HRESP  out  1  response to master
slvHADDRbase, slvHADDRmask  in  SLAVES x HADDR_SIZE  per-slave decode base / mask
slvHSEL  out  SLAVES  one-hot select per slave port
slvHADDR, slvHWDATA, slvHWRITE, slvHSIZE, slvHBURST, slvHPROT, slvHTRANS, slvHMASTLOCK  out  widths as master side  shared to all slave ports
slvHREADY  out  1  HREADY to slave ports
slvHRDATA  in  SLAVES x HDATA_SIZE  read data per slave port
slvHREADYOUT, slvHRESP  in  SLAVES  per-slave ready / response
slv_granted  in  SLAVES  slave port s currently grants this master
can_switch  out  SLAVES  slave port s may re-arbitrate away from this master

Behaviour:
- Decode: hit[s] = (mask[s] != 0) & (((mst_HADDR ^ base[s]) & mask[s]) == 0). Lowest index wins. No hit means unmapped.
- Accept: an address phase is sampled when mst_HSEL & mst_HREADY & mst_HREADYOUT. Only NONSEQ(2) or SEQ(3) are active transfers.
- FSM states: IDLE, DATA, WAIT, ERR1, ERR2. Reset state is IDLE.
- IDLE:
  - accepted active transfer to granted slave s -> DATA, dp_idx = s;
  - to ungranted s -> latch address-phase signals and s into hold register, go to WAIT;
  - unmapped -> ERR1;
  - IDLE/BUSY or no HSEL -> stay IDLE.
- DATA: while slvHREADYOUT[dp_idx] = 0, stay DATA. When it is 1, apply the same accept rules as IDLE; no accept -> IDLE.
- WAIT:
  - drive held signals to slave s, slvHSEL[s] = 1, slvHREADY = slvHREADYOUT[s];
  - held SEQ is forced to NONSEQ;
  - when slv_granted[s] & slvHREADYOUT[s] -> DATA, dp_idx = s.
- ERR1 -> ERR2 unconditionally. ERR2 accepts a new address phase like IDLE, otherwise -> IDLE.
- Outputs per state:
  - mst_HREADYOUT: IDLE 1, DATA slvHREADYOUT[dp_idx], WAIT 0, ERR1 0, ERR2 1.
  - mst_HRESP: DATA slvHRESP[dp_idx], ERR1/ERR2 1, else 0.
  - mst_HRDATA = slvHRDATA[dp_idx].
- Address-phase forwarding outside WAIT:
  - slvHSEL[decoded s] = mst_HSEL; the other bits are 0;
  - unmapped -> all 0;
  - address/control signals pass combinationally;
  - slvHREADY = mst_HREADYOUT.
- slvHWDATA = mst_HWDATA (pass-through; the master holds HWDATA while HREADYOUT is low).
- can_switch[s] = 0 when slvHSEL[s] & (slvHMASTLOCK | slvHTRANS in {BUSY, SEQ}). Otherwise 1.
- Reset values: FSM IDLE, hold register 0, dp_idx 0, mst_HREADYOUT 1, mst_HRESP 0, slvHSEL 0, can_switch all 1.
- Reset asserted mid-WAIT or mid-ERR: the held transfer is discarded, no slave is selected, and outputs return to the reset values immediately (asynchronously).
- A new master address phase presented during WAIT/ERR1 is not sampled, because HREADYOUT is 0.

Test Plan:
- Slave 1 base 0x1000, mask 0xF000, granted: NONSEQ write 0x1004 -> slvHSEL = 0b10 the same cycle; next cycle DATA, mst_HREADYOUT follows slvHREADYOUT[1]; HWDATA 0xA5A5 passed through.
- Slave 2 not granted: NONSEQ read 0x2000 -> WAIT, mst_HREADYOUT = 0, slvHTRANS = NONSEQ held. Assert slv_granted[2] after 3 cycles -> DATA next cycle, mst_HRDATA = slvHRDATA[2] = 0xDEADBEEF.
- Unmapped 0xF000 NONSEQ -> ERR1 (HREADYOUT 0, HRESP 1), then ERR2 (HREADYOUT 1, HRESP 1), then IDLE with HRESP 0.
- Locked INCR4 to slave 0 -> can_switch[0] = 0 for all beats and returns to 1 after the final IDLE address phase.
- Burst SEQ to ungranted slave 3 -> held HTRANS driven as NONSEQ(2) while in WAIT.
- HRESETn low during WAIT -> slvHSEL = 0, mst_HREADYOUT = 1, FSM IDLE after release.
